// File: rtl/dmem_latency_ctrl.sv
// Multi-cycle MEM-stage data memory: stalls the pipeline for LATENCY cycles per access.
// Optional macro LAST_READ_BYPASS_EN adds a last-load tag that completes repeat loads in one cycle.
module dmem_latency_ctrl #(
  parameter int LATENCY = 4,
  parameter int DEPTH   = 256,
  parameter int AW      = 8
) (
  input  logic        CLK,
  input  logic        CLR,
  input  logic        mem_rd,
  input  logic        mem_wr,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        stall,
  output logic        done
);

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  state_t          state, state_nxt;
  logic [3:0]      cnt, cnt_nxt;
  logic [31:0]     RAM [DEPTH];

  logic [AW-1:0]   idx_in;
  logic            req, accept, commit, hit;
  logic [AW-1:0]   idx_p0;
  logic [31:0]     wdata_p0;
  logic            wr_p0;
  logic [AW-1:0]   cmt_idx;
  logic [31:0]     cmt_wdata;
  logic            cmt_wr;
  logic            unused_addr;

  assign idx_in      = addr[AW+1:2];
  assign req         = mem_rd | mem_wr;
  assign unused_addr = ^{addr[31:AW+2], addr[1:0]};

  // With LATENCY=1 the commit happens on the accepting edge, so it must use live inputs.
  assign cmt_idx   = (state == IDLE) ? idx_in : idx_p0;
  assign cmt_wdata = (state == IDLE) ? wdata  : wdata_p0;
  assign cmt_wr    = (state == IDLE) ? mem_wr : wr_p0;

`ifdef LAST_READ_BYPASS_EN
  logic [AW-1:0] tag;
  logic          tag_vld;

  assign hit = (state == IDLE) && mem_rd && !mem_wr && tag_vld && (tag == idx_in);

  always_ff @(posedge CLK) begin
    if (!CLR) begin
      tag_vld <= 1'b0;
    end else if (accept && mem_wr) begin
      tag_vld <= 1'b0;
    end else if (commit && !cmt_wr) begin
      tag_vld <= 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (commit && !cmt_wr) tag <= cmt_idx;
  end
`else
  assign hit = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    stall     = 1'b0;
    done      = 1'b0;
    accept    = 1'b0;
    commit    = 1'b0;
    case (state)
      IDLE: begin
        if (hit) begin
          done = 1'b1;
        end else if (req) begin
          stall  = 1'b1;
          accept = 1'b1;
          if (LATENCY == 1) begin
            state_nxt = DONE;
            commit    = 1'b1;
          end else begin
            state_nxt = WAIT;
            cnt_nxt   = CNT_INIT;
          end
        end
      end
      WAIT: begin
        stall   = 1'b1;
        cnt_nxt = cnt - 4'd1;
        if (cnt == 4'd1) begin
          state_nxt = DONE;
          commit    = 1'b1;
        end
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!CLR) begin
      state <= IDLE;
      cnt   <= 4'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Request capture stage: holds the accepted request while the pipeline inputs are don't-care.
  always_ff @(posedge CLK) begin
    if (accept) begin
      idx_p0   <= idx_in;
      wdata_p0 <= wdata;
      wr_p0    <= mem_wr;
    end
  end

  // Commit stage: a reset edge suppresses the write so an aborted store never lands.
  always_ff @(posedge CLK) begin
    if (CLR && commit && cmt_wr) RAM[cmt_idx] <= cmt_wdata;
  end

  always_ff @(posedge CLK) begin
    if (!CLR) begin
      rdata <= 32'd0;
    end else if (commit && !cmt_wr) begin
      rdata <= RAM[cmt_idx];
    end
  end

endmodule

// File: tb/tb_dmem_latency_ctrl.sv
// Randomized self-checking bench for dmem_latency_ctrl against a transaction-level memory model.
module tb_dmem_latency_ctrl;

  localparam int LAT = 4;

  logic        CLK = 1'b0;
  logic        CLR;
  logic        mem_rd, mem_wr;
  logic [31:0] addr, wdata;
  logic [31:0] rdata;
  logic        stall, done;

  int n_vec = 0;
  int n_err = 0;

  logic [31:0] mem_m [256];
  logic [31:0] rd_m;
  logic        vld_m;
  logic [7:0]  tag_m;

  dmem_latency_ctrl #(.LATENCY(LAT), .DEPTH(256), .AW(8)) dut (
    .CLK(CLK), .CLR(CLR), .mem_rd(mem_rd), .mem_wr(mem_wr),
    .addr(addr), .wdata(wdata), .rdata(rdata), .stall(stall), .done(done)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h want 0x%08h", tag, obs, exp);
    end
  endtask

  // One memory instruction as the pipeline presents it; returns cycles spent stalled.
  task automatic do_txn(input logic rd, input logic wr, input logic [31:0] a,
                        input logic [31:0] wd, input bit scramble, output int lat);
    logic [7:0] idx;
    int  exp_lat;
    bit  seen;
    idx = a[9:2];
    if (wr) begin
      mem_m[idx] = wd;
      vld_m      = 1'b0;
      exp_lat    = LAT;
    end else begin
      exp_lat = LAT;
`ifdef LAST_READ_BYPASS_EN
      if (vld_m && tag_m == idx) exp_lat = 0;
`endif
      rd_m  = mem_m[idx];
      vld_m = 1'b1;
      tag_m = idx;
    end
    mem_rd = rd; mem_wr = wr; addr = a; wdata = wd;
    lat = 0; seen = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge CLK);
      if (done) begin
        seen = 1;
        chk("stall_in_done", 32'(stall), 32'd0);
        chk("rdata", rdata, rd_m);
        break;
      end
      if (stall) lat++;
      @(posedge CLK); #1;
      if (scramble) begin addr = $urandom; wdata = $urandom; end
    end
    chk("done_seen", 32'(seen), 32'd1);
    chk("latency", 32'(lat), 32'(exp_lat));
    if (wr) chk("ram", dut.RAM[idx], mem_m[idx]);
    @(posedge CLK); #1;
    mem_rd = 1'b0; mem_wr = 1'b0;
  endtask

  task automatic idle_chk(input string tag);
    @(negedge CLK);
    chk({tag, "_stall"}, 32'(stall), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
    @(posedge CLK); #1;
  endtask

  initial begin
    int l1, l2;
    logic [31:0] a;
    logic [3:0]  ri;
    CLR = 1'b0; mem_rd = 1'b0; mem_wr = 1'b0; addr = '0; wdata = '0;
    rd_m = '0; vld_m = 1'b0; tag_m = '0;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    chk("rst_stall", 32'(stall), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    @(posedge CLK); #1;
    CLR = 1'b1;

    // Known contents for the indices exercised below
    for (int i = 0; i < 16; i++) do_txn(1'b0, 1'b1, 32'(i) << 2, $urandom, 1'b0, l1);
    do_txn(1'b0, 1'b1, 32'h14, 32'hDEADBEEF, 1'b0, l1);

    do_txn(1'b1, 1'b0, 32'h14, 32'h0, 1'b0, l1);
    chk("load14_rdata", rdata, 32'hDEADBEEF);

    do_txn(1'b0, 1'b1, 32'h20, 32'h12345678, 1'b0, l1);
    do_txn(1'b1, 1'b0, 32'h20, 32'h0, 1'b0, l2);
    chk("st_ld_cycles", 32'(l1 + 1 + l2 + 1), 32'd10);
    chk("st_ld_value", rdata, 32'h12345678);

    do_txn(1'b1, 1'b0, 32'h404, 32'h0, 1'b0, l1);
    chk("alias_404", rdata, mem_m[1]);

    do_txn(1'b1, 1'b1, 32'h0, 32'hA5A5A5A5, 1'b0, l1);
    chk("both_ram0", dut.RAM[0], 32'hA5A5A5A5);
    idle_chk("idle_after_both");

    // Bypass scenario: repeated load, then separated by a store
    do_txn(1'b1, 1'b0, 32'h14, 32'h0, 1'b0, l1);
    do_txn(1'b1, 1'b0, 32'h14, 32'h0, 1'b0, l2);
`ifdef LAST_READ_BYPASS_EN
    chk("bypass_hit_lat", 32'(l2), 32'd0);
`else
    chk("nobypass_lat", 32'(l2), 32'(LAT));
`endif
    do_txn(1'b0, 1'b1, 32'h30, 32'h0BADF00D, 1'b0, l1);
    do_txn(1'b1, 1'b0, 32'h14, 32'h0, 1'b0, l2);
    chk("post_store_lat", 32'(l2), 32'(LAT));

    // Reset while a store waits: the write must be dropped
    do_txn(1'b0, 1'b1, 32'hC, 32'h11, 1'b0, l1);
    mem_wr = 1'b1; addr = 32'hC; wdata = 32'h99;
    @(posedge CLK); #1;
    @(posedge CLK); #1;
    CLR = 1'b0; mem_wr = 1'b0;
    @(posedge CLK); #1;
    rd_m = '0; vld_m = 1'b0;
    @(negedge CLK);
    chk("abort_stall", 32'(stall), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_ram3", dut.RAM[3], 32'h11);
    chk("abort_rdata", rdata, 32'd0);
    @(posedge CLK); #1;
    CLR = 1'b1;
    idle_chk("after_abort");
    idle_chk("after_abort2");

    // Random traffic over a small index window with aliased upper bits
    for (int t = 0; t < 150; t++) begin
      logic r, w;
      r  = 1'($urandom);
      w  = 1'($urandom);
      if (!r && !w) r = 1'b1;
      ri = 4'($urandom);
      a  = {22'($urandom), 4'b0, ri, 2'($urandom)};
      if ($urandom_range(0, 3) == 0) a[31:2] = {a[31:6], 4'd5};
      do_txn(r, w, a, $urandom, 1'($urandom), l1);
      if ($urandom_range(0, 4) == 0) idle_chk("rand_idle");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
